mcp_logic_unit: RTL and testbench
=================================

Name: mcp_logic_unit

Overview:
Parametrised, registered bitwise logic unit for the MIPS multicycle datapath; generalises the single OR gate to N-bit AND/OR/XOR/NOR plus multi-beat OR/AND accumulation.
Sits between the register-read stage and the ALUOut register. Uses a valid/ready handshake so the control FSM can stall on it.
Single-beat ops return one result per accepted beat. Accumulate ops fold a burst of operands into one result.

Parameters:
WIDTH, 32, operand/result width in bits (>=1)
MAX_BEATS, 16, maximum beats in one accumulate burst (>=2)
CNT_W, $clog2(MAX_BEATS+1), width of beat counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock; the only clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
in_op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ACC_OR, 101 ACC_AND, 110/111 reserved
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored by ACC ops)
in_last  input  1  final beat of an accumulate burst (ignored by single-beat ops)
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_zero  output  1  out_result == 0
out_count  output  CNT_W  beats folded into this result (1 for single-beat ops)
out_err  output  1  result came from a reserved opcode
out_forced  output  1  burst terminated by MAX_BEATS, not by in_last

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_result=0, out_zero=1, out_count=0, out_err=0, out_forced=0, FSM=IDLE, accumulator=0, beat counter=0. A reset during a burst discards the burst and any held result.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_ready). A result is consumed when out_valid && out_ready.
- Output register: one entry. Outputs are stable while out_valid && !out_ready. If a result is consumed and a new result is produced in the same cycle, the register reloads with no bubble. If a result is consumed and nothing new is produced, out_valid drops to 0.
- Single-beat ops (000–011), IDLE only: the result (a&b, a|b, a^b, ~(a|b)) is registered one cycle after acceptance, so latency is 1. out_count=1; out_err=0; out_forced=0.
- Reserved ops (110/111), IDLE only: result=0, out_err=1, out_count=1, latency 1.
- FSM IDLE: an accepted ACC op latches the op, sets acc = identity op in_a (identity is 0 for OR, all-ones for AND), and sets count=1.
  - If in_last is also set, the result is produced with latency 1 and the FSM stays in IDLE.
  - Otherwise the FSM goes to ACCUM.
- FSM ACCUM: in_ready is 1 here, because out_valid is necessarily 0.
  - Each accepted beat does acc = acc op in_a and count = count+1, using the latched op. in_op on later beats is ignored.
  - Burst ends on an accepted beat with in_last=1, or on the beat that makes count == MAX_BEATS; the latter sets out_forced=1 even if in_last=0.
  - At burst end the result is registered with out_count=count and the FSM returns to IDLE.
  - Cycles with no beat do not change state.
- out_zero is registered together with out_result.
- All arithmetic is bitwise and width-preserving; there are no carries. The counter never exceeds MAX_BEATS.

Decomposition:
- Shared package mcp_pkg:
  - op encoding localparams OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ACC_OR, OP_ACC_AND
  - FSM state encoding ST_IDLE, ST_ACCUM
- Sub-module: mcp_logic_core, purely combinational, (op, a, b) -> result/err. The top keeps the FSM, accumulator, counter and output register.

Test Plan:
- Reset with random inputs, then reset=0 -> out_valid=0, out_zero=1, out_count=0, in_ready=1.
- OR, a=0x0000_F0F0, b=0x0F0F_0000, out_ready=1 -> one cycle later out_result=0x0F0F_F0F0, out_count=1, out_zero=0. NOR on the same operands -> 0xF0F0_0F0F.
- ACC_OR burst of 0x1, 0x4, 0x100 (last on the third beat), op field changed to AND on beat 2 -> out_result=0x105, out_count=3, out_forced=0; the change to AND is ignored.
- ACC_AND with 16 beats of 0xFFFF_FFFF, in_last never set -> result 0xFFFF_FFFF, out_count=16, out_forced=1, FSM back in IDLE.
- XOR 0xAAAA_AAAA^0xAAAA_AAAA with out_ready=0 for 3 cycles -> out_result=0, out_zero=1 held stable and in_ready=0. Then out_ready=1 together with a new AND beat -> the next cycle shows the AND result with no bubble.
- Reset asserted mid-ACC_OR burst (after 2 beats) -> no result emitted. The next single OR beat yields out_count=1 with a fresh result; op 111 -> out_err=1, out_result=0.

Source files
------------

// File: rtl/mcp_pkg.sv
// rtl/mcp_pkg.sv - shared opcode and FSM state encodings for the logic unit
package mcp_pkg;

   localparam logic [2:0] OP_AND     = 3'b000;
   localparam logic [2:0] OP_OR      = 3'b001;
   localparam logic [2:0] OP_XOR     = 3'b010;
   localparam logic [2:0] OP_NOR     = 3'b011;
   localparam logic [2:0] OP_ACC_OR  = 3'b100;
   localparam logic [2:0] OP_ACC_AND = 3'b101;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   // True for the opcodes that start a multi-beat fold.
   function automatic logic is_acc_op(input logic [2:0] op);
      return (op == OP_ACC_OR) || (op == OP_ACC_AND);
   endfunction

endpackage

// File: rtl/mcp_logic_core.sv
// rtl/mcp_logic_core.sv - combinational bitwise AND/OR/XOR/NOR with reserved-op flag
module mcp_logic_core
   import mcp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // Any opcode outside the four plain gates yields zero and flags an error.
   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         default: err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/mcp_logic_unit.sv
// rtl/mcp_logic_unit.sv - registered logic unit with handshake and OR/AND burst accumulation
module mcp_logic_unit
   import mcp_pkg::*;
#(
   parameter int  WIDTH     = 32,
   parameter int  MAX_BEATS = 16,
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err,
   output logic             out_forced
);

   state_e           state_q, state_d;
   logic             acc_and_q, acc_and_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             out_zero_q, out_zero_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_err_q, out_err_d;
   logic             out_forced_q, out_forced_d;

   logic             accept;
   logic             fold_and;
   logic [2:0]       core_op;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_res;
   logic             core_err;
   logic [CNT_W-1:0] cnt_inc;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign cnt_inc  = cnt_q + CNT_W'(1);

   // Steer the core: plain ops pass through; folds reuse AND/OR against the identity or the running accumulator.
   always_comb begin
      fold_and = acc_and_q;
      core_op  = in_op;
      core_b   = in_b;
      if (state_q == ST_ACCUM) begin
         core_op = acc_and_q ? OP_AND : OP_OR;
         core_b  = acc_q;
      end else if (is_acc_op(in_op)) begin
         fold_and = (in_op == OP_ACC_AND);
         core_op  = fold_and ? OP_AND : OP_OR;
         core_b   = fold_and ? {WIDTH{1'b1}} : '0;
      end
   end

   mcp_logic_core #(.WIDTH(WIDTH)) u_core (
      .op     (core_op),
      .a      (in_a),
      .b      (core_b),
      .result (core_res),
      .err    (core_err)
   );

   // Next-state for the burst FSM, accumulator, counter and the one-entry result register.
   always_comb begin
      state_d      = state_q;
      acc_and_d    = acc_and_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_result_d = out_result_q;
      out_zero_d   = out_zero_q;
      out_count_d  = out_count_q;
      out_err_d    = out_err_q;
      out_forced_d = out_forced_q;

      if (accept) begin
         if (state_q == ST_IDLE) begin
            if (is_acc_op(in_op) && !in_last) begin
               state_d   = ST_ACCUM;
               acc_and_d = fold_and;
               acc_d     = core_res;
               cnt_d     = CNT_W'(1);
            end else begin
               // Plain op, reserved op, or a one-beat burst: result appears next cycle.
               out_valid_d  = 1'b1;
               out_result_d = core_res;
               out_zero_d   = (core_res == '0);
               out_count_d  = CNT_W'(1);
               out_err_d    = core_err && !is_acc_op(in_op);
               out_forced_d = 1'b0;
            end
         end else begin
            acc_d = core_res;
            cnt_d = cnt_inc;
            if (in_last || (cnt_inc == CNT_W'(MAX_BEATS))) begin
               state_d      = ST_IDLE;
               acc_d        = '0;
               cnt_d        = '0;
               out_valid_d  = 1'b1;
               out_result_d = core_res;
               out_zero_d   = (core_res == '0);
               out_count_d  = cnt_inc;
               out_err_d    = 1'b0;
               out_forced_d = (cnt_inc == CNT_W'(MAX_BEATS));
            end
         end
      end
   end

   // State and output registers; reset drops any burst in flight and any held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         acc_and_q    <= 1'b0;
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b1;
         out_count_q  <= '0;
         out_err_q    <= 1'b0;
         out_forced_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_and_q    <= acc_and_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_zero_q   <= out_zero_d;
         out_count_q  <= out_count_d;
         out_err_q    <= out_err_d;
         out_forced_q <= out_forced_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_count  = out_count_q;
   assign out_err    = out_err_q;
   assign out_forced = out_forced_q;

endmodule

// File: tb/tb_mcp_logic_unit.sv
// tb/tb_mcp_logic_unit.sv - scoreboard bench for mcp_logic_unit with randomized traffic
module tb_mcp_logic_unit;

   localparam int WIDTH     = 32;
   localparam int MAX_BEATS = 16;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic [CNT_W-1:0] out_count;
   logic             out_err;
   logic             out_forced;

   mcp_logic_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_count  (out_count),
      .out_err    (out_err),
      .out_forced (out_forced)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] res;
      int               cnt;
      bit               err;
      bit               forced;
   } exp_t;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   bit   bp_random = 1'b0;
   bit   mon_en    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] res, input int cnt, input bit err, input bit forced);
      exp_t e;
      e.res = res; e.cnt = cnt; e.err = err; e.forced = forced;
      sb.push_back(e);
   endtask

   // Reference for single-beat ops, straight from the opcode table.
   function automatic logic [WIDTH-1:0] single_ref(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a | b);
         default: return '0;
      endcase
   endfunction

   // Monitor: every consumed result is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en && !reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h, required no result", out_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 64'(out_result), 64'(e.res));
            chk("zero",   64'(out_zero),   64'(e.res == '0));
            chk("count",  64'(out_count),  64'(e.cnt));
            chk("err",    64'(out_err),    64'(e.err));
            chk("forced", 64'(out_forced), 64'(e.forced));
         end
      end
   end

   // Random consumer backpressure, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Present one beat (called just after a rising edge) and return just after the edge that takes it.
   task automatic beat(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic last);
      int w = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, required 1", w);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_last = 1'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((sb.size() != 0 || out_valid) && w < 500) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain", 64'(sb.size()), 64'(0));
   endtask

   // A full burst: expected value is the fold of all operands from the identity.
   task automatic burst(input bit is_and, input int len, input bit last_at_max);
      logic [WIDTH-1:0] ops[$];
      logic [WIDTH-1:0] acc;
      logic [WIDTH-1:0] v;
      acc = is_and ? {WIDTH{1'b1}} : '0;
      for (int i = 0; i < len; i++) begin
         v = is_and ? ~($urandom & $urandom & $urandom) : ($urandom & $urandom & $urandom);
         ops.push_back(v);
         acc = is_and ? (acc & v) : (acc | v);
      end
      push(acc, len, 1'b0, len == MAX_BEATS);
      for (int i = 0; i < len; i++) begin
         logic [2:0] op;
         logic       last;
         op   = (i == 0) ? (is_and ? 3'b101 : 3'b100) : 3'($urandom);
         last = (i == len - 1) && ((len < MAX_BEATS) || last_at_max);
         beat(op, ops[i], $urandom, last);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;

      // Reset while the inputs wiggle.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom); in_op = 3'($urandom); in_a = $urandom; in_b = $urandom;
         in_last = 1'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("rst_valid",  64'(out_valid),  64'(0));
      chk("rst_zero",   64'(out_zero),   64'(1));
      chk("rst_count",  64'(out_count),  64'(0));
      chk("rst_result", 64'(out_result), 64'(0));
      chk("rst_ready",  64'(in_ready),   64'(1));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      mon_en    = 1'b1;

      // OR then NOR, one-cycle latency.
      push(32'h0F0F_F0F0, 1, 1'b0, 1'b0);
      beat(3'b001, 32'h0000_F0F0, 32'h0F0F_0000, 1'b0);
      chk("or_latency", 64'(out_valid), 64'(1));
      push(32'hF0F0_0F0F, 1, 1'b0, 1'b0);
      beat(3'b011, 32'h0000_F0F0, 32'h0F0F_0000, 1'b0);
      chk("nor_latency", 64'(out_valid), 64'(1));
      drain();

      // ACC_OR with the op field changed on later beats.
      push(32'h0000_0105, 3, 1'b0, 1'b0);
      beat(3'b100, 32'h1, $urandom, 1'b0);
      beat(3'b000, 32'h4, $urandom, 1'b0);
      beat(3'b000, 32'h100, $urandom, 1'b1);
      drain();

      // ACC_AND terminated by the beat limit.
      push(32'hFFFF_FFFF, MAX_BEATS, 1'b0, 1'b1);
      for (int i = 0; i < MAX_BEATS; i++) beat(3'b101, 32'hFFFF_FFFF, $urandom, 1'b0);
      chk("forced_latency", 64'(out_valid), 64'(1));
      drain();

      // Stalled XOR result, then a back-to-back AND with no bubble.
      out_ready = 1'b0;
      push(32'h0, 1, 1'b0, 1'b0);
      beat(3'b010, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid",  64'(out_valid),  64'(1));
         chk("stall_result", 64'(out_result), 64'(0));
         chk("stall_zero",   64'(out_zero),   64'(1));
         chk("stall_ready",  64'(in_ready),   64'(0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push(32'h0204_0608, 1, 1'b0, 1'b0);
      beat(3'b000, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      chk("nobubble_valid",  64'(out_valid),  64'(1));
      chk("nobubble_result", 64'(out_result), 64'h0204_0608);
      drain();

      // Reset in the middle of a burst: nothing may come out of it.
      beat(3'b100, 32'h0000_00F0, $urandom, 1'b0);
      beat(3'b100, 32'h0000_0F00, $urandom, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 64'(out_valid), 64'(0));
      chk("midrst_count", 64'(out_count), 64'(0));
      @(posedge clk);
      #1;
      push(32'h1357_9BDF, 1, 1'b0, 1'b0);
      beat(3'b001, 32'h1250_0000, 32'h0107_9BDF, 1'b0);
      push(32'h0, 1, 1'b1, 1'b0);
      beat(3'b111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
      drain();

      // Randomized mix under random backpressure.
      bp_random = 1'b1;
      for (int t = 0; t < 300; t++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 6) begin
            logic [2:0]       op;
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            op = 3'($urandom_range(0, 5));
            if (op > 3'd3) op = op + 3'd2;
            a = $urandom; b = $urandom;
            push(single_ref(op, a, b), 1, op > 3'd3, 1'b0);
            beat(op, a, b, 1'($urandom));
         end else begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? MAX_BEATS : $urandom_range(1, MAX_BEATS);
            burst(1'($urandom), len, 1'($urandom));
         end
         if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
